// File: rtl/nco_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : nco_phase_controller
// Purpose  : Sequencer and configuration front-end for a quarter-wave I/Q sine
//            lookup. Runs the phase accumulator and the sample-rate divider.
//            Drives the lookup clock-enable and phase input, and tags issued
//            samples so that o_valid marks each new I/Q pair on the lookup
//            outputs. Retunes are phase-continuous: the accumulator is never
//            cleared by a configuration change.
// Optional : NCO_DITHER_EN - adds a 16-bit LFSR phase dither before truncation
// Ports    : i_clk, i_reset_n (async, active-low)
//            i_start / i_stop       - run control pulses
//            i_cfg_valid/o_cfg_ready, i_cfg_ftw/i_cfg_poff/i_cfg_div - config
//            o_ce, o_phase          - lookup clock-enable and phase
//            o_valid                - one-cycle pulse per new valid sample
//            o_busy                 - high while running or draining
// Revision : 1.0 - initial release
// ============================================================================
module nco_phase_controller #(
  parameter int AW  = 32,  // accumulator / tuning word width
  parameter int PW  = 12,  // phase width to lookup
  parameter int DW  = 16,  // divider width
  parameter int LAT = 5    // lookup latency in ce-qualified edges (>= 2)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  input  logic [AW-1:0] i_cfg_ftw,
  input  logic [PW-1:0] i_cfg_poff,
  input  logic [DW-1:0] i_cfg_div,
  output logic          o_ce,
  output logic [PW-1:0] o_phase,
  output logic          o_valid,
  output logic          o_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]     state;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  ftw;
  logic [PW-1:0]  poff;
  logic [DW-1:0]  div;
  logic [DW-1:0]  cnt;
  logic [AW-1:0]  sh_ftw;
  logic [PW-1:0]  sh_poff;
  logic [DW-1:0]  sh_div;
  logic           pending;
  logic [LAT-1:0] tags;

  logic           strobe;
  logic           cfg_xfer;
  logic           go;
  logic           drain_done;
  logic [AW-1:0]  phase_src;
  logic [PW-1:0]  phase_next;

  assign strobe      = (state != ST_IDLE) && (cnt == '0);
  assign o_cfg_ready = (state == ST_IDLE) || ((state == ST_RUN) && !pending);
  assign cfg_xfer    = i_cfg_valid && o_cfg_ready;
  // stop wins over a simultaneous start
  assign go          = (state == ST_IDLE) && i_start && !i_stop;
  assign drain_done  = (state == ST_DRAIN) && (tags == '0);
  assign o_busy      = (state != ST_IDLE);

`ifdef NCO_DITHER_EN
  localparam int DITH_W = ((AW - PW) < 16) ? (AW - PW) : 16;
  logic [15:0] lfsr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lfsr <= 16'hACE1;
    end else if (go) begin
      lfsr <= 16'hACE1;
    end else if (strobe && (state == ST_RUN)) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign phase_src = acc + AW'(lfsr[DITH_W-1:0]);
`else
  assign phase_src = acc;
`endif

  // top PW bits of the (optionally dithered) accumulator, then offset
  assign phase_next = PW'(phase_src >> (AW - PW)) + poff;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (go)         state <= ST_RUN;
        ST_RUN:   if (i_stop)     state <= ST_DRAIN;
        ST_DRAIN: if (drain_done) state <= ST_IDLE;
        default:                  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc     <= '0;
      ftw     <= '0;
      poff    <= '0;
      div     <= '0;
      cnt     <= '0;
      sh_ftw  <= '0;
      sh_poff <= '0;
      sh_div  <= '0;
      pending <= 1'b0;
      tags    <= '0;
      o_ce    <= 1'b0;
      o_phase <= '0;
      o_valid <= 1'b0;
    end else begin
      o_ce    <= strobe;
      // tag reached the last stage at the previous strobe; its ce edge
      // lands the sample on the lookup outputs
      o_valid <= o_ce && tags[LAT-1];

      if (go) begin
        acc <= '0;
        cnt <= '0;
      end else if (strobe) begin
        cnt  <= div;
        tags <= {tags[LAT-2:0], (state == ST_RUN)};
        if (state == ST_RUN) begin
          o_phase <= phase_next;
          acc     <= acc + ftw;
        end
      end else if (state != ST_IDLE) begin
        cnt <= cnt - 1'b1;
      end

      // Configuration: direct in IDLE, shadowed while running. The strobe
      // that applies the shadow still used the old values above.
      if (state == ST_IDLE) begin
        if (cfg_xfer) begin
          ftw  <= i_cfg_ftw;
          poff <= i_cfg_poff;
          div  <= i_cfg_div;
        end
      end else if (state == ST_RUN) begin
        if (strobe && pending) begin
          ftw     <= sh_ftw;
          poff    <= sh_poff;
          div     <= sh_div;
          pending <= 1'b0;
        end
        if (cfg_xfer) begin
          sh_ftw  <= i_cfg_ftw;
          sh_poff <= i_cfg_poff;
          sh_div  <= i_cfg_div;
          pending <= 1'b1;
        end
      end else if (drain_done && pending) begin
        ftw     <= sh_ftw;
        poff    <= sh_poff;
        div     <= sh_div;
        pending <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nco_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_phase_controller
// Purpose  : Self-checking bench for nco_phase_controller. A cycle-level
//            reference model predicts every o_ce (with its phase) and every
//            o_valid pulse into queues; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_phase_controller;

  localparam int AW  = 32;
  localparam int PW  = 12;
  localparam int DW  = 16;
  localparam int LAT = 5;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic          i_cfg_valid = 1'b0;
  logic          o_cfg_ready;
  logic [AW-1:0] i_cfg_ftw = '0;
  logic [PW-1:0] i_cfg_poff = '0;
  logic [DW-1:0] i_cfg_div = '0;
  logic          o_ce;
  logic [PW-1:0] o_phase;
  logic          o_valid;
  logic          o_busy;

  nco_phase_controller #(.AW(AW), .PW(PW), .DW(DW), .LAT(LAT)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_ftw   (i_cfg_ftw),
    .i_cfg_poff  (i_cfg_poff),
    .i_cfg_div   (i_cfg_div),
    .o_ce        (o_ce),
    .o_phase     (o_phase),
    .o_valid     (o_valid),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int cyc; logic [PW-1:0] ph;} ce_t;
  ce_t ceq[$];
  int  vq[$];
  int  run_idx[$];   // strobe indices of RUN samples still awaiting o_valid

  int            m_st;
  logic [AW-1:0] m_acc, m_ftw, sh_ftw;
  logic [PW-1:0] m_poff, sh_poff, m_phase;
  int            m_div, sh_div, m_cnt;
  bit            m_pend;
  int            sc;        // strobes completed so far
  int            last_run;  // strobe index of the most recent RUN sample
  logic [15:0]   m_lfsr;

  task automatic model_reset();
    m_st = S_IDLE; m_acc = '0; m_ftw = '0; m_poff = '0; m_div = 0; m_cnt = 0;
    sh_ftw = '0; sh_poff = '0; sh_div = 0; m_pend = 1'b0; m_phase = '0;
    sc = 0; last_run = -1000; m_lfsr = 16'hACE1;
    run_idx.delete(); ceq.delete(); vq.delete();
  endtask

  // One clock cycle: drive inputs, check status outputs, advance the model.
  task automatic step(input bit st, input bit sp, input bit cv, input logic [AW-1:0] f,
                      input logic [PW-1:0] p, input logic [DW-1:0] d);
    bit rdy, strobe, xfer, in_flight;
    logic [AW-1:0] s;
    ce_t e;
    @(negedge clk);
    i_start = st; i_stop = sp; i_cfg_valid = cv;
    i_cfg_ftw = f; i_cfg_poff = p; i_cfg_div = d;
    #1;
    rdy = (m_st == S_IDLE) || (m_st == S_RUN && !m_pend);
    chk("cfg_ready", o_cfg_ready, rdy);
    chk("busy", o_busy, m_st != S_IDLE);
    xfer      = cv && rdy;
    strobe    = (m_st != S_IDLE) && (m_cnt == 0);
    in_flight = (last_run >= sc - LAT);   // a RUN sample still in the lookup pipe
    if (strobe) begin
      if (m_st == S_RUN) begin
`ifdef NCO_DITHER_EN
        s = m_acc + {16'h0, m_lfsr};
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
        s = m_acc;
`endif
        m_phase = s[AW-1:AW-PW] + m_poff;
        m_acc   = m_acc + m_ftw;
        run_idx.push_back(sc);
        last_run = sc;
      end
      e.cyc = cyc + 1; e.ph = m_phase;
      ceq.push_back(e);
      // sample issued LAT-1 strobes ago reaches the outputs on this one
      if (run_idx.size() > 0 && run_idx[0] == sc - (LAT - 1)) begin
        void'(run_idx.pop_front());
        vq.push_back(cyc + 2);
      end
      sc++;
      m_cnt = m_div;
    end else if (m_st != S_IDLE) begin
      m_cnt--;
    end
    case (m_st)
      S_IDLE: begin
        if (xfer) begin m_ftw = f; m_poff = p; m_div = int'(d); end
        if (st && !sp) begin
          m_st = S_RUN; m_acc = '0; m_cnt = 0; m_lfsr = 16'hACE1;
        end
      end
      S_RUN: begin
        if (strobe && m_pend) begin
          m_ftw = sh_ftw; m_poff = sh_poff; m_div = sh_div; m_pend = 1'b0;
        end
        if (xfer) begin sh_ftw = f; sh_poff = p; sh_div = int'(d); m_pend = 1'b1; end
        if (sp) m_st = S_DRAIN;
      end
      default: begin
        if (!in_flight) begin
          m_st = S_IDLE;
          if (m_pend) begin
            m_ftw = sh_ftw; m_poff = sh_poff; m_div = sh_div; m_pend = 1'b0;
          end
        end
      end
    endcase
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (m_st != S_IDLE && k < 400) begin
      step(0, 0, 0, '0, '0, '0);
      k++;
    end
    step(0, 0, 0, '0, '0, '0);
    chk("idle_after_drain", o_busy, 1'b0);
  endtask

  // ---------------- monitor ----------------
  ce_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_ce) begin
        if (ceq.size() == 0) chk("ce_unexpected", o_ce, 1'b0);
        else begin
          me = ceq.pop_front();
          chk("ce_cycle", cyc, me.cyc);
          chk("ce_phase", o_phase, me.ph);
        end
      end else if (ceq.size() > 0 && ceq[0].cyc <= cyc) begin
        chk("ce_missing", o_ce, 1'b1);
        void'(ceq.pop_front());
      end
      if (o_valid) begin
        if (vq.size() == 0) chk("valid_unexpected", o_valid, 1'b0);
        else chk("valid_cycle", cyc, vq.pop_front());
      end else if (vq.size() > 0 && vq[0] <= cyc) begin
        chk("valid_missing", o_valid, 1'b1);
        void'(vq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #3;
    chk("rst_ce", o_ce, 1'b0);
    chk("rst_phase", o_phase, '0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_cfg_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic tone, div=0
    step(0, 0, 1, 32'h0100_0000, 12'h000, 16'd0);
    step(1, 1, 0, '0, '0, '0);   // start&stop together: stays idle
    step(1, 0, 0, '0, '0, '0);
    idle_n(20);
    step(0, 1, 0, '0, '0, '0);
    drain();

    // div=3, then phase-continuous retune 0100_0000 -> 0200_0000
    step(0, 0, 1, 32'h0100_0000, 12'h000, 16'd3);
    step(1, 0, 0, '0, '0, '0);
    idle_n(6);
    step(0, 0, 1, 32'h0200_0000, 12'h000, 16'd3);
    idle_n(20);
    step(0, 1, 0, '0, '0, '0);
    drain();

    // half-rate tone with offset
    step(0, 0, 1, 32'h8000_0000, 12'hC00, 16'd0);
    step(1, 0, 0, '0, '0, '0);
    idle_n(9);
    step(0, 1, 0, '0, '0, '0);
    drain();

    // randomized runs with config offers and control noise
    for (int seg = 0; seg < 6; seg++) begin
      step(0, 0, 1, $urandom, PW'($urandom), DW'($urandom_range(0, 5)));
      step(1, 0, 0, '0, '0, '0);
      for (int i = 0; i < 40; i++)
        step($urandom_range(0, 15) == 0, 1'b0, $urandom_range(0, 3) == 0,
             $urandom, PW'($urandom), DW'($urandom_range(0, 5)));
      step(0, 1, $urandom_range(0, 1) == 1, $urandom, PW'($urandom), DW'($urandom_range(0, 5)));
      for (int i = 0; i < 3; i++)
        step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1,
             $urandom, PW'($urandom), '0);
      drain();
    end

    // zero tuning word: phase stays at the offset (0) with or without dither
    step(0, 0, 1, 32'h0, 12'h000, 16'd1);
    step(1, 0, 0, '0, '0, '0);
    idle_n(12);
    step(0, 1, 0, '0, '0, '0);
    drain();

    // asynchronous reset in the middle of a run
    step(0, 0, 1, 32'h0123_4567, 12'h100, 16'd0);
    step(1, 0, 0, '0, '0, '0);
    idle_n(8);
    @(negedge clk);
    i_start = 1'b0; i_stop = 1'b0; i_cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ce", o_ce, 1'b0);
    chk("arst_phase", o_phase, '0);
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_ready", o_cfg_ready, 1'b1);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // recovery after reset
    step(0, 0, 1, 32'h0100_0000, 12'h000, 16'd2);
    step(1, 0, 0, '0, '0, '0);
    idle_n(15);
    step(0, 1, 0, '0, '0, '0);
    drain();
    idle_n(3);

    chk("ce_queue_empty", ceq.size(), 0);
    chk("valid_queue_empty", vq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
